// File: rtl/exc_sequencer_if.sv
// exc_sequencer_if
// Groups the signals between the main control unit, the exception
// sequencer and the address mux / EPC / PC registers.
//   iord_sel_in          selector proposed by the main control unit
//   req_opcode           invalid-opcode exception request
//   req_overflow         ALU overflow exception request
//   req_div0             divide-by-zero exception request
//   iord_sel             selector actually driven to the address mux
//   epc_wr, mem_rd,
//   pc_wr, pc_src_exc    datapath strobes owned by the sequencer
//   busy                 main control must stall while high
//   exc_ack              one-cycle pulse when the handler PC is loaded
//   cause                code of the last exception taken
// modport slave  : the sequencer side
// modport master : the control / datapath side
interface exc_sequencer_if;
    logic [2:0] iord_sel_in;
    logic       req_opcode;
    logic       req_overflow;
    logic       req_div0;
    logic [2:0] iord_sel;
    logic       epc_wr;
    logic       mem_rd;
    logic       pc_wr;
    logic       pc_src_exc;
    logic       busy;
    logic       exc_ack;
    logic [1:0] cause;

    modport slave (
        input  iord_sel_in, req_opcode, req_overflow, req_div0,
        output iord_sel, epc_wr, mem_rd, pc_wr, pc_src_exc, busy, exc_ack, cause
    );

    modport master (
        output iord_sel_in, req_opcode, req_overflow, req_div0,
        input  iord_sel, epc_wr, mem_rd, pc_wr, pc_src_exc, busy, exc_ack, cause
    );
endinterface

// File: rtl/exc_sequencer.sv
// exc_sequencer
// Owns the memory-address mux selector. While idle it forwards the main
// control unit's selector; on an exception request it runs the fixed
// sequence SAVE (write EPC) -> ADDR (address handler vector, start read)
// -> WAIT x MEM_LAT -> LOAD (write PC from memory data) -> IDLE.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-low reset
//   bus     exc_sequencer_if.slave (requests, selector, strobes, status)
// Parameter:
//   MEM_LAT memory read latency in cycles, 0..15
module exc_sequencer #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic           clock,
    input  logic           reset,
    exc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SAVE = 3'd1,
        ADDR = 3'd2,
        WAIT = 3'd3,
        LOAD = 3'd4
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state_reg, state_next;
    logic [2:0] pending_reg, pending_next;
    logic [1:0] cause_reg, cause_next;
    logic [2:0] vector_reg, vector_next;
    logic [3:0] count_reg, count_next;

    // bit 0 opcode, bit 1 overflow, bit 2 div0; lower index wins
    logic [2:0] req;
    logic [2:0] candidates;
    logic [2:0] take;
    logic [1:0] take_code;

    logic [2:0] sel;
    logic       epc_wr;
    logic       mem_rd;
    logic       pc_wr;
    logic       pc_src_exc;
    logic       exc_ack;
    logic       busy;

    assign req        = {bus.req_div0, bus.req_overflow, bus.req_opcode};
    assign candidates = pending_reg | req;

    // One-hot priority pick: a cause is taken only if no higher-priority
    // candidate is present.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_take
            if (gi == 0) begin : g_top
                assign take[gi] = candidates[gi];
            end else begin : g_lower
                assign take[gi] = candidates[gi] & ~(|candidates[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        take_code = 2'd0;
        if (take[0]) begin
            take_code = 2'd1;
        end else if (take[1]) begin
            take_code = 2'd2;
        end else if (take[2]) begin
            take_code = 2'd3;
        end
    end

    always_comb begin
        state_next   = state_reg;
        // Requests are recorded every cycle, whatever the state.
        pending_next = candidates;
        cause_next   = cause_reg;
        vector_next  = vector_reg;
        count_next   = count_reg;
        sel          = 3'b000;
        epc_wr       = 1'b0;
        mem_rd       = 1'b0;
        pc_wr        = 1'b0;
        pc_src_exc   = 1'b0;
        exc_ack      = 1'b0;
        busy         = 1'b1;

        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                sel  = bus.iord_sel_in;
                if (|candidates) begin
                    // Clearing the taken bit also swallows a same-cause
                    // request arriving this cycle.
                    pending_next = candidates & ~take;
                    cause_next   = take_code;
                    // Vector codes 011/100/101 are the cause code plus two.
                    vector_next  = {1'b0, take_code} + 3'd2;
                    state_next   = SAVE;
                end
            end
            SAVE: begin
                sel        = 3'b000;
                epc_wr     = 1'b1;
                state_next = ADDR;
            end
            ADDR: begin
                sel        = vector_reg;
                mem_rd     = 1'b1;
                count_next = LAT;
                state_next = (LAT != 4'd0) ? WAIT : LOAD;
            end
            WAIT: begin
                sel        = vector_reg;
                mem_rd     = 1'b1;
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                sel        = vector_reg;
                pc_wr      = 1'b1;
                pc_src_exc = 1'b1;
                exc_ack    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pending_reg <= 3'b000;
            cause_reg   <= 2'b00;
            vector_reg  <= 3'b000;
            count_reg   <= 4'd0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            cause_reg   <= cause_next;
            vector_reg  <= vector_next;
            count_reg   <= count_next;
        end
    end

    assign bus.iord_sel   = sel;
    assign bus.epc_wr     = epc_wr;
    assign bus.mem_rd     = mem_rd;
    assign bus.pc_wr      = pc_wr;
    assign bus.pc_src_exc = pc_src_exc;
    assign bus.exc_ack    = exc_ack;
    assign bus.busy       = busy;
    assign bus.cause      = cause_reg;
endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception sequencer for the multicycle datapath. It owns the 3-bit memory-address mux selector. In normal operation it forwards the main control unit's selector unchanged. On an invalid-opcode, overflow or divide-by-zero request it takes over that selector and runs a fixed sequence: save EPC, address the handler-vector word, wait for memory, load PC. It sits between the main control FSM and the address mux, EPC register and PC register.

## Interface
- MEM_LAT, 1, memory read latency in cycles between the address being presented and data being valid; legal range 0..15.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iord_sel_in  in  3  selector from the main control unit; forwarded while idle.
- req_opcode  in  1  invalid-opcode exception request, one-cycle pulse or level.
- req_overflow  in  1  ALU overflow exception request.
- req_div0  in  1  divide-by-zero exception request.
- iord_sel  out  3  address mux selector: 000 PC, 001 ALU result, 010 ALUOut, 011 opcode vector, 100 overflow vector, 101 div0 vector.
- epc_wr  out  1  EPC register write enable.
- mem_rd  out  1  memory read strobe.
- pc_wr  out  1  PC write enable.
- pc_src_exc  out  1  selects memory data as the PC source.
- busy  out  1  high in every state except IDLE; the main control stalls while it is high.
- exc_ack  out  1  one-cycle pulse in the LOAD state.
- cause  out  2  registered cause of the last exception taken: 00 none, 01 opcode, 10 overflow, 11 div0.

## Operation
- States: IDLE, SAVE, ADDR, WAIT, LOAD.
- All outputs are Moore outputs decoded from the state, except `iord_sel` in IDLE, which equals `iord_sel_in` combinationally.
- **Pending register** (3 bits), one bit per cause:
  - Every cycle, in every state, it ORs in the request inputs.
  - When a cause is taken, its bit is cleared. A request for that same cause arriving in the same cycle is absorbed, not re-pended.
- **Priority:** opcode > overflow > div0. Candidates are (pending OR request inputs).
- **IDLE:**
  - If any candidate exists, take the highest-priority one: latch its code into `cause` and into an internal vector selector (011/100/101), then go to SAVE.
  - Otherwise stay in IDLE.
- **SAVE:** `iord_sel`=000, `epc_wr`=1. Next state is ADDR.
- **ADDR:** `iord_sel`=vector, `mem_rd`=1, 4-bit wait counter loaded with MEM_LAT.
  - Next state is WAIT if MEM_LAT>0, else LOAD.
- **WAIT:** `iord_sel`=vector, `mem_rd`=1, counter decrements.
  - When the counter reaches 1 this cycle, next state is LOAD.
- **LOAD:** `iord_sel`=vector, `pc_wr`=1, `pc_src_exc`=1, `exc_ack`=1. Next state is IDLE.
- Requests arriving while busy are recorded in the pending register only. The sequence in progress is never aborted or restarted.
- Back-to-back exceptions: after LOAD, IDLE lasts exactly one cycle if anything is pending, then the next sequence starts.
- `epc_wr`, `mem_rd` and `pc_wr` are never asserted in IDLE.

## Timing
- **Reset** (asynchronous, active-low), effective immediately:
  - state=IDLE, pending=000, `cause`=00, counter=0, vector=000.
  - Strobe outputs (`epc_wr`, `mem_rd`, `pc_wr`, `pc_src_exc`, `exc_ack`) are 0 and `busy`=0.
  - `iord_sel` follows `iord_sel_in`.
  - Reset asserted mid-sequence: no further strobes occur and all pending requests are lost.
- **Latency:** request sampled at edge k:
  - SAVE is active in cycle k+1, ADDR in k+2.
  - WAIT spans k+3..k+2+MEM_LAT.
  - LOAD (`exc_ack`) is in cycle k+3+MEM_LAT; IDLE resumes at k+4+MEM_LAT.
  - With MEM_LAT=0, LOAD is in cycle k+3.
- `cause` updates on the edge leaving IDLE and holds until the next exception is taken.
- `busy` rises in the cycle after the request edge; main control must hold its own outputs inactive while `busy`=1.

## Test plan
- Reset then idle: `iord_sel_in` steps through 000, 001, 010 -> `iord_sel` mirrors each the same cycle; all strobes 0; `cause`=00.
- Single overflow pulse, MEM_LAT=1 -> next 4 cycles are SAVE(`iord_sel`=000, `epc_wr`), ADDR(100, `mem_rd`), WAIT(100, `mem_rd`), LOAD(100, `pc_wr`, `pc_src_exc`, `exc_ack`); then `cause`=10 and `busy`=0.
- Simultaneous req_div0 and req_opcode pulses -> opcode serviced first (`cause`=01, vector 011); after one IDLE cycle div0 serviced (`cause`=11, vector 101); exactly two `exc_ack` pulses.
- req_div0 pulsed during WAIT of an opcode sequence, MEM_LAT=3 -> first sequence finishes unchanged with 3 WAIT cycles; div0 sequence starts 2 cycles after its LOAD.
- MEM_LAT=0, req_opcode -> LOAD 3 cycles after the request edge; no WAIT state visited.
- reset asserted during ADDR with req_overflow pending -> all strobes drop immediately; after release the block is idle with `cause`=00 and no sequence runs.
